// File: rtl/svm_pkg.sv
// Shared definitions for the RBF-kernel datapath: default sizes, accumulator
// width, accumulator control states and sign-magnitude field helpers.
package svm_pkg;

    localparam int unsigned XLEN_PIXEL_DEF = 8;
    localparam int unsigned N_FEATURES_DEF = 16;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Sum of n squares of (2*xlen-1)-bit magnitudes can never overflow this width.
    function automatic int unsigned acc_width(input int unsigned xlen, input int unsigned n);
        return 2 * (2 * xlen - 1) + $clog2(n);
    endfunction

    function automatic logic sm_sign(input logic [63:0] v, input int unsigned w);
        logic [63:0] t;
        t = v >> (w - 1);
        return t[0];
    endfunction

    function automatic logic [63:0] sm_mag(input logic [63:0] v, input int unsigned w);
        return v & ((64'd1 << (w - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/sm_square.sv
// Combinational unsigned magnitude squarer; kept separate so a DSP-mapped or
// pipelined multiplier can be dropped in without touching the accumulator.
module sm_square #(
    parameter int unsigned MAG_W = 15
) (
    input  logic [MAG_W-1:0]   mag_i,
    output logic [2*MAG_W-1:0] sq_o
);

    assign sq_o = {{MAG_W{1'b0}}, mag_i} * {{MAG_W{1'b0}}, mag_i};

endmodule

// File: rtl/sq_dist_accum.sv
// Squares sign-magnitude differences beat by beat and accumulates N_FEATURES of
// them into a squared Euclidean distance, returned over a valid/ready handshake.
module sq_dist_accum
    import svm_pkg::*;
#(
    parameter int unsigned XLEN_PIXEL = XLEN_PIXEL_DEF,
    parameter int unsigned N_FEATURES = N_FEATURES_DEF,
    parameter int unsigned ACC_W      = acc_width(XLEN_PIXEL, N_FEATURES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [2*XLEN_PIXEL-1:0] diff_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ACC_W-1:0]        dist_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned MAG_W = 2 * XLEN_PIXEL - 1;
    localparam int unsigned SQ_W  = 2 * MAG_W;
    localparam int unsigned CNT_W = $clog2(N_FEATURES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEATURES - 1);

    state_e state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] mag_q;
    logic             cap_valid_q, cap_first_q, cap_last_q;

    logic [SQ_W-1:0]  sq;
    logic [SQ_W-1:0]  sq_q;
    logic             sq_valid_q, sq_first_q, sq_last_q;

    logic [ACC_W-1:0] acc_q, acc_next, dist_q;
    logic             out_valid_q;
    logic             beat_fire, out_fire;

    assign in_ready  = (state_q == ST_ACCEPT);
    assign out_valid = out_valid_q;
    assign dist_out  = dist_q;
    assign beat_fire = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;

    // Sign bit is dropped here, so negative zero squares to zero.
    assign mag = MAG_W'(sm_mag(64'(diff_in), 2 * XLEN_PIXEL));

    sm_square #(
        .MAG_W(MAG_W)
    ) u_sm_square (
        .mag_i(mag_q),
        .sq_o (sq)
    );

    assign acc_next = sq_first_q ? ACC_W'(sq_q) : acc_q + ACC_W'(sq_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (flush) begin
            state_d = ST_ACCEPT;
            count_d = '0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (beat_fire) begin
                        if (count_q == LAST_IDX) begin
                            count_d = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sq_valid_q && sq_last_q) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_fire) state_d = ST_ACCEPT;
                end
                default: state_d = ST_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCEPT;
            count_q     <= '0;
            mag_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_first_q <= 1'b0;
            cap_last_q  <= 1'b0;
            sq_q        <= '0;
            sq_valid_q  <= 1'b0;
            sq_first_q  <= 1'b0;
            sq_last_q   <= 1'b0;
            acc_q       <= '0;
            dist_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (flush) begin
                cap_valid_q <= 1'b0;
                sq_valid_q  <= 1'b0;
                acc_q       <= '0;
                out_valid_q <= 1'b0;
            end else begin
                cap_valid_q <= beat_fire;
                if (beat_fire) begin
                    mag_q       <= mag;
                    cap_first_q <= (count_q == '0);
                    cap_last_q  <= (count_q == LAST_IDX);
                end
                sq_valid_q <= cap_valid_q;
                if (cap_valid_q) begin
                    sq_q       <= sq;
                    sq_first_q <= cap_first_q;
                    sq_last_q  <= cap_last_q;
                end
                if (sq_valid_q) begin
                    acc_q <= acc_next;
                    if (sq_last_q) begin
                        dist_q      <= acc_next;
                        out_valid_q <= 1'b1;
                    end
                end else if (out_fire) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sq_dist_accum.sv
// Directed bench for sq_dist_accum (XLEN_PIXEL=8, N_FEATURES=4) with a result
// scoreboard checked whenever an output handshake is about to happen.
module tb_sq_dist_accum;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] diff_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dist_out;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int errors;
    longint unsigned exp_q[$];

    sq_dist_accum #(
        .XLEN_PIXEL(8),
        .N_FEATURES(4),
        .ACC_W     (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .diff_in  (diff_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dist_out (dist_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint unsigned sqm(input logic [15:0] v);
        longint unsigned m;
        m = longint'(v & 16'h7FFF);
        return m * m;
    endfunction

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] v);
        int n;
        in_valid = 1'b1;
        diff_in  = v;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk(64'(in_ready), 64'd1, "beat_ready_timeout");
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(64'(out_valid), 64'd1, tag);
        if (out_valid && out_ready) tick();
    endtask

    // Scoreboard: compare on the cycle whose closing edge completes the handshake.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_output: observed %0d expected none", dist_out);
            end else begin
                chk(64'(dist_out), 64'(exp_q.pop_front()), "scoreboard_dist");
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        diff_in   = '0;
        out_ready = 1'b1;

        #12;
        chk(64'(in_ready), 64'd1, "reset_in_ready");
        chk(64'(out_valid), 64'd0, "reset_out_valid");
        chk(64'(dist_out), 64'd0, "reset_dist_out");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic vector with latency and ready checks.
        exp_q.push_back(sqm(16'h0003) + sqm(16'h8004) + sqm(16'h0000) + sqm(16'h8001));
        beat(16'h0003);
        beat(16'h8004);
        beat(16'h0000);
        beat(16'h8001);
        chk(64'(in_ready), 64'd0, "basic_drain_in_ready");
        chk(64'(out_valid), 64'd0, "basic_lat0_out_valid");
        tick();
        chk(64'(out_valid), 64'd0, "basic_lat1_out_valid");
        tick();
        chk(64'(out_valid), 64'd1, "basic_lat2_out_valid");
        chk(64'(dist_out), 64'd26, "basic_dist");
        chk(64'(in_ready), 64'd0, "basic_hold_in_ready");
        tick();
        chk(64'(out_valid), 64'd0, "basic_out_valid_one_cycle");
        chk(64'(in_ready), 64'd1, "basic_ready_after");

        // Full-scale and negative zero.
        exp_q.push_back(64'd4294705156);
        for (int i = 0; i < 4; i++) beat(16'hFFFF);
        wait_out("fullscale_timeout");
        exp_q.push_back(64'd0);
        for (int i = 0; i < 4; i++) beat(16'h8000);
        wait_out("negzero_timeout");

        // Input gaps and output backpressure.
        begin
            logic [6:0]  pat;
            logic [15:0] vals[4];
            int k;
            pat = 7'b1011001;
            vals[0] = 16'h0007;
            vals[1] = 16'h8002;
            vals[2] = 16'h0001;
            vals[3] = 16'h0003;
            k = 0;
            out_ready = 1'b0;
            exp_q.push_back(64'd63);
            for (int i = 6; i >= 0; i--) begin
                in_valid = pat[i];
                diff_in  = pat[i] ? vals[k] : 16'h0055;
                tick();
                if (pat[i]) k++;
            end
            in_valid = 1'b0;
            wait_out("gap_timeout");
            in_valid = 1'b1;
            diff_in  = 16'h0009;
            for (int i = 0; i < 5; i++) begin
                chk(64'(out_valid), 64'd1, "bp_out_valid_held");
                chk(64'(dist_out), 64'd63, "bp_dist_stable");
                chk(64'(in_ready), 64'd0, "bp_in_ready");
                tick();
            end
            out_ready = 1'b1;
            chk(64'(in_ready), 64'd0, "bp_ready_on_handshake");
            tick();
            in_valid = 1'b0;
            chk(64'(out_valid), 64'd0, "bp_out_valid_cleared");
            chk(64'(in_ready), 64'd1, "bp_ready_next_cycle");
        end

        // Back-to-back vectors.
        exp_q.push_back(64'd30);
        exp_q.push_back(64'd100);
        beat(16'h0001);
        beat(16'h0002);
        beat(16'h0003);
        beat(16'h0004);
        for (int i = 0; i < 4; i++) beat(16'h0005);
        wait_out("b2b_timeout");

        // Flush mid-vector with a beat presented on the flush cycle.
        beat(16'h0005);
        beat(16'h0006);
        in_valid = 1'b1;
        diff_in  = 16'h0007;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk(64'(in_ready), 64'd1, "flush_in_ready");
        chk(64'(out_valid), 64'd0, "flush_out_valid");
        exp_q.push_back(64'd4);
        for (int i = 0; i < 4; i++) beat(16'h0001);
        wait_out("flush_timeout");

        // Asynchronous reset mid-vector.
        for (int i = 0; i < 3; i++) beat(16'h0003);
        #2;
        rst = 1'b1;
        #1;
        chk(64'(in_ready), 64'd1, "arst_in_ready");
        chk(64'(out_valid), 64'd0, "arst_out_valid");
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk(64'(out_valid), 64'd0, "arst_no_partial_output");
            tick();
        end
        exp_q.push_back(64'd16);
        for (int i = 0; i < 4; i++) beat(16'h0002);
        wait_out("arst_vec_timeout");

        for (int i = 0; i < 4; i++) tick();
        chk(64'(exp_q.size()), 64'd0, "scoreboard_empty");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
